// File: rtl/gvideo_pkg.sv
// Shared video-pipeline definitions: counter/colour widths, glyph geometry
// and the scroll FSM state encoding.
package gvideo_pkg;
    localparam int CNT_W  = 11;
    localparam int RGB_W  = 12;
    localparam int POS_W  = 12;
    localparam int CHAR_W = 8;
    localparam int CHAR_H = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCROLL = 2'd1,
        ST_HOLD   = 2'd2
    } scroll_state_t;
endpackage

// File: rtl/draw_text_scroller_if.sv
// VGA pixel-stream bus: counters, sync/blank timing and the pixel colour.
interface draw_text_scroller_if;
    import gvideo_pkg::*;

    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;
    logic [RGB_W-1:0] rgb;

    modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/delay.sv
// Generic register delay line, CLK_DEL stages deep, cleared on reset.
module delay #(
    parameter int WIDTH   = 1,
    parameter int CLK_DEL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] pipe [CLK_DEL];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CLK_DEL; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < CLK_DEL; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign dout = pipe[CLK_DEL-1];
endmodule

// File: rtl/text_scroll_fsm.sv
// Frame-synchronous credits scroll: moves the box top from Y_START up to
// Y_STOP, one STEP every FRAMES_PER_STEP vsync rising edges.
module text_scroll_fsm
    import gvideo_pkg::*;
#(
    parameter int Y_START         = 768,
    parameter int Y_STOP          = 100,
    parameter int STEP            = 1,
    parameter int FRAMES_PER_STEP = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vsync_in,
    input  logic             start,
    input  logic             stop,
    input  logic             loop,
    output logic [POS_W-1:0] y_pos,
    output logic             busy,
    output logic             done
);
    localparam logic [POS_W-1:0] Y_START_P = POS_W'(Y_START);
    localparam logic [POS_W-1:0] Y_STOP_P  = POS_W'(Y_STOP);
    localparam logic [POS_W-1:0] STEP_P    = POS_W'(STEP);
    localparam logic [15:0]      FR_LAST   = 16'(FRAMES_PER_STEP - 1);

    scroll_state_t    state;
    logic             vsync_q;
    logic [15:0]      fcnt;
    logic             frame_tick;
    logic [POS_W-1:0] y_next;

    assign frame_tick = vsync_in & ~vsync_q;
    assign y_next     = (y_pos <= Y_STOP_P + STEP_P) ? Y_STOP_P : y_pos - STEP_P;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            y_pos   <= Y_START_P;
            fcnt    <= '0;
            vsync_q <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            vsync_q <= vsync_in;
            done    <= 1'b0;
            // stop wins over start and over a coincident frame tick
            if (stop) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                y_pos <= Y_START_P;
                fcnt  <= '0;
            end else begin
                case (state)
                    ST_IDLE, ST_HOLD: begin
                        if (start) begin
                            state <= ST_SCROLL;
                            busy  <= 1'b1;
                            y_pos <= Y_START_P;
                            fcnt  <= '0;
                        end
                    end
                    ST_SCROLL: begin
                        if (frame_tick) begin
                            if (fcnt == FR_LAST) begin
                                fcnt <= '0;
                                if (y_pos == Y_STOP_P) begin
                                    if (loop) y_pos <= Y_START_P;
                                    else      state <= ST_HOLD;
                                end else begin
                                    y_pos <= y_next;
                                    if (y_next == Y_STOP_P) begin
                                        done <= 1'b1;
                                        if (!loop) state <= ST_HOLD;
                                    end
                                end
                            end else begin
                                fcnt <= fcnt + 16'd1;
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: rtl/draw_text_scroller.sv
// Scaled character-grid overlay with its own vertical credits scroll; drives
// an external char-code ROM and font ROM and merges glyphs into the VGA stream.
module draw_text_scroller
    import gvideo_pkg::*;
#(
    parameter int COL_W           = 4,
    parameter int ROW_W           = 3,
    parameter int SCALE_LOG2      = 0,
    parameter int ROM_LAT         = 1,
    parameter int Y_START         = 768,
    parameter int Y_STOP          = 100,
    parameter int STEP            = 1,
    parameter int FRAMES_PER_STEP = 2
) (
    input  logic                   pclk,
    input  logic                   rst,
    draw_text_scroller_if.slave    vin,
    draw_text_scroller_if.master   vout,
    input  logic [POS_W-1:0]       xpos,
    input  logic [7:0]             char_pixels,
    input  logic [RGB_W-1:0]       color_fg,
    input  logic [RGB_W-1:0]       color_bg,
    input  logic                   transparent_bg,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   loop,
    output logic [ROW_W+COL_W-1:0] char_xy,
    output logic [3:0]             char_line,
    output logic                   busy,
    output logic                   done
);
    localparam int          BUS_W = 2*CNT_W + 4 + RGB_W;
    localparam logic [12:0] BOX_W = 13'(CHAR_W << (COL_W + SCALE_LOG2));
    localparam logic [12:0] BOX_H = 13'(CHAR_H << (ROW_W + SCALE_LOG2));

    function automatic logic [RGB_W-1:0] pick_pixel(
        input logic glyph_on, input logic tbg,
        input logic [RGB_W-1:0] fg, input logic [RGB_W-1:0] bg,
        input logic [RGB_W-1:0] under);
        if (glyph_on) return fg;
        return tbg ? under : bg;
    endfunction

    logic [POS_W-1:0] y_pos;

    text_scroll_fsm #(
        .Y_START(Y_START), .Y_STOP(Y_STOP), .STEP(STEP),
        .FRAMES_PER_STEP(FRAMES_PER_STEP)
    ) u_fsm (
        .clk(pclk), .rst(rst), .vsync_in(vin.vsync),
        .start(start), .stop(stop), .loop(loop),
        .y_pos(y_pos), .busy(busy), .done(done)
    );

    logic [12:0]        hx, vy, xp, yp, dx_raw, dy_raw;
    logic [COL_W+2:0]   dx;
    logic [ROW_W+3:0]   dy;
    logic               in_box;

    always_comb begin
        hx     = {2'b00, vin.hcount};
        vy     = {2'b00, vin.vcount};
        xp     = {1'b0, xpos};
        yp     = {1'b0, y_pos};
        dx_raw = hx - xp;
        dy_raw = vy - yp;
        dx     = (COL_W+3)'(dx_raw >> SCALE_LOG2);
        dy     = (ROW_W+4)'(dy_raw >> SCALE_LOG2);
        in_box = (hx >= xp) && (hx < xp + BOX_W) && (vy >= yp) && (vy < yp + BOX_H);
    end

    // Stage 1 registers the ROM address; stages 2..ROM_LAT wait for the font row
    logic       inside_p [ROM_LAT];
    logic [2:0] col_p    [ROM_LAT];

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            char_xy   <= '0;
            char_line <= '0;
            for (int k = 0; k < ROM_LAT; k++) begin
                inside_p[k] <= 1'b0;
                col_p[k]    <= '0;
            end
        end else begin
            char_xy     <= {dy[ROW_W+3:4], dx[COL_W+2:3]};
            char_line   <= dy[3:0];
            inside_p[0] <= in_box && busy;
            col_p[0]    <= dx[2:0];
            for (int k = 1; k < ROM_LAT; k++) begin
                inside_p[k] <= inside_p[k-1];
                col_p[k]    <= col_p[k-1];
            end
        end
    end

    logic [BUS_W-1:0] bus_d;
    logic [CNT_W-1:0] hc_d, vc_d;
    logic             hs_d, vs_d, hb_d, vb_d;
    logic [RGB_W-1:0] rgb_d;

    delay #(.WIDTH(BUS_W), .CLK_DEL(ROM_LAT)) u_delay (
        .clk(pclk), .rst(rst),
        .din({vin.hcount, vin.vcount, vin.hsync, vin.vsync, vin.hblnk, vin.vblnk, vin.rgb}),
        .dout(bus_d)
    );

    assign {hc_d, vc_d, hs_d, vs_d, hb_d, vb_d, rgb_d} = bus_d;

    // Final stage: the font row is valid here, aligned with the delayed timing
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            vout.hcount <= '0;
            vout.vcount <= '0;
            vout.hsync  <= 1'b0;
            vout.vsync  <= 1'b0;
            vout.hblnk  <= 1'b0;
            vout.vblnk  <= 1'b0;
            vout.rgb    <= '0;
        end else begin
            vout.hcount <= hc_d;
            vout.vcount <= vc_d;
            vout.hsync  <= hs_d;
            vout.vsync  <= vs_d;
            vout.hblnk  <= hb_d;
            vout.vblnk  <= vb_d;
            if (hb_d || vb_d)
                vout.rgb <= '0;
            else if (inside_p[ROM_LAT-1])
                vout.rgb <= pick_pixel(char_pixels[3'd7 - col_p[ROM_LAT-1]], transparent_bg,
                                       color_fg, color_bg, rgb_d);
            else
                vout.rgb <= rgb_d;
        end
    end
endmodule

// File: tb/tb_draw_text_scroller.sv
// Scoreboard bench: two scroller instances (default, and 2x scale with a
// three-cycle ROM) fed from one video bus, with hand-computed pixel results.
module tb_draw_text_scroller;
    import gvideo_pkg::*;

    logic pclk = 1'b0;
    logic rst  = 1'b1;
    always #5 pclk = ~pclk;

    draw_text_scroller_if vin();
    draw_text_scroller_if vo1();
    draw_text_scroller_if vo2();

    logic [11:0] xpos, fg, bg;
    logic        tbg;
    logic        start1, stop1, loop1, start2, stop2, loop2;
    logic [7:0]  px1, px2, rom2_q;
    logic [6:0]  xy1, xy2;
    logic [3:0]  ln1, ln2;
    logic        busy1, done1, busy2, done2;

    draw_text_scroller dut1 (
        .pclk(pclk), .rst(rst), .vin(vin.slave), .vout(vo1.master),
        .xpos(xpos), .char_pixels(px1), .color_fg(fg), .color_bg(bg),
        .transparent_bg(tbg), .start(start1), .stop(stop1), .loop(loop1),
        .char_xy(xy1), .char_line(ln1), .busy(busy1), .done(done1)
    );

    draw_text_scroller #(.SCALE_LOG2(1), .ROM_LAT(3)) dut2 (
        .pclk(pclk), .rst(rst), .vin(vin.slave), .vout(vo2.master),
        .xpos(xpos), .char_pixels(px2), .color_fg(fg), .color_bg(bg),
        .transparent_bg(tbg), .start(start2), .stop(stop2), .loop(loop2),
        .char_xy(xy2), .char_line(ln2), .busy(busy2), .done(done2)
    );

    // Font model: character column 1 holds 8'h40, every other character 8'h80.
    function automatic logic [7:0] rom(input logic [6:0] xy);
        return (xy[3:0] == 4'd1) ? 8'h40 : 8'h80;
    endfunction

    // ROM_LAT counts from the registered address: 1 = no extra register.
    assign px1 = rom(xy1);
    always @(posedge pclk) begin
        rom2_q <= rom(xy2);
        px2    <= rom2_q;
    end

    typedef struct {
        string       nm;
        int          due;
        int          dut;
        logic [11:0] rgb;
        logic [10:0] hc;
        logic [10:0] vc;
        logic        hs;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   done_cnt1 = 0;

    always @(posedge pclk) cyc <= cyc + 1;
    always @(negedge pclk) if (done1) done_cnt1 <= done_cnt1 + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp_v);
        end
    endtask

    always @(negedge pclk) begin
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            mon_e = sbq.pop_front();
            if (mon_e.due != cyc) check({mon_e.nm, "_late"}, cyc, mon_e.due);
            if (mon_e.dut == 0) begin
                check({mon_e.nm, "_rgb"}, vo1.rgb, mon_e.rgb);
                check({mon_e.nm, "_hc"},  vo1.hcount, mon_e.hc);
                check({mon_e.nm, "_vc"},  vo1.vcount, mon_e.vc);
                check({mon_e.nm, "_hs"},  vo1.hsync, mon_e.hs);
            end else begin
                check({mon_e.nm, "_rgb"}, vo2.rgb, mon_e.rgb);
                check({mon_e.nm, "_hc"},  vo2.hcount, mon_e.hc);
                check({mon_e.nm, "_vc"},  vo2.vcount, mon_e.vc);
                check({mon_e.nm, "_hs"},  vo2.hsync, mon_e.hs);
            end
        end
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic pix(input string nm, input int d, input int h, input int v,
                       input logic [11:0] rgb, input logic [11:0] exp_rgb,
                       input logic blank = 1'b0, input logic hs = 1'b0);
        exp_t e;
        vin.hcount = 11'(h);
        vin.vcount = 11'(v);
        vin.rgb    = rgb;
        vin.hblnk  = blank;
        vin.hsync  = hs;
        e.nm  = nm;
        e.dut = d;
        e.due = cyc + ((d == 0) ? 2 : 4);
        e.rgb = exp_rgb;
        e.hc  = 11'(h);
        e.vc  = 11'(v);
        e.hs  = hs;
        sbq.push_back(e);
        tick();
    endtask

    task automatic drain();
        int k = 0;
        while (sbq.size() > 0 && k < 50) begin
            tick();
            k++;
        end
        if (sbq.size() > 0) begin
            check("drain", sbq.size(), 0);
            sbq.delete();
        end
    endtask

    task automatic frame();
        vin.vsync = 1'b1;
        tick();
        vin.vsync = 1'b0;
        tick();
    endtask

    task automatic pulse_start1();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        xpos = 12'd100; fg = 12'hF0F; bg = 12'h00A; tbg = 1'b0;
        start1 = 0; stop1 = 0; loop1 = 0; start2 = 0; stop2 = 0; loop2 = 0;
        vin.hcount = 11'd5; vin.vcount = 11'd7; vin.hsync = 1'b1; vin.vsync = 1'b0;
        vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = 12'h123;

        repeat (3) tick();
        check("rst_rgb", vo1.rgb, 0);
        check("rst_hcount", vo1.hcount, 0);
        check("rst_hsync", vo1.hsync, 0);
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_char_xy", xy1, 0);
        check("rst_busy2", busy2, 0);
        rst = 1'b0;
        vin.hsync = 1'b0;
        tick();

        pix("idle_nodraw", 0, 100, 768, 12'h111, 12'h111);
        drain();
        pulse_start1();
        check("start_busy", busy1, 1);

        pix("fg_left",    0, 100, 768, 12'h211, 12'hF0F);
        pix("bg_next",    0, 101, 768, 12'h212, 12'h00A);
        pix("left_out",   0,  99, 768, 12'h213, 12'h213);
        pix("right_out",  0, 228, 768, 12'h214, 12'h214);
        pix("right_last", 0, 227, 768, 12'h215, 12'h00A);
        pix("bottom_in",  0, 100, 895, 12'h216, 12'hF0F);
        pix("bottom_out", 0, 100, 896, 12'h217, 12'h217);
        pix("above_out",  0, 100, 767, 12'h218, 12'h218);
        pix("blank",      0, 100, 768, 12'h219, 12'h000, 1'b1);
        pix("hsync_lag",  0,  50,  10, 12'h21A, 12'h21A, 1'b0, 1'b1);
        drain();

        repeat (1335) frame();
        check("no_early_done", done_cnt1, 0);
        check("scroll_busy", busy1, 1);
        pix("y101_in",  0, 100, 101, 12'h300, 12'hF0F);
        pix("y100_out", 0, 100, 100, 12'h301, 12'h301);
        drain();
        frame();
        check("done_at_stop", done_cnt1, 1);
        pix("y100_in", 0, 100, 100, 12'h302, 12'hF0F);
        drain();
        repeat (10) frame();
        check("done_once", done_cnt1, 1);
        check("hold_busy", busy1, 1);
        pix("hold_stable", 0, 100, 100, 12'h303, 12'hF0F);
        drain();

        stop1 = 1'b1; tick(); stop1 = 1'b0; tick();
        check("stop_busy", busy1, 0);
        loop1 = 1'b1;
        pulse_start1();
        repeat (1336) frame();
        check("loop_done", done_cnt1, 2);
        check("loop_busy", busy1, 1);
        pix("loop_at_stop", 0, 100, 100, 12'h310, 12'hF0F);
        drain();
        frame();
        frame();
        pix("loop_wrap_in",  0, 100, 768, 12'h311, 12'hF0F);
        pix("loop_wrap_abv", 0, 100, 767, 12'h312, 12'h312);
        pix("loop_old_out",  0, 100, 100, 12'h313, 12'h313);
        drain();
        check("loop_busy_wrap", busy1, 1);

        stop1 = 1'b1; start1 = 1'b1; vin.vsync = 1'b1;
        tick();
        stop1 = 1'b0; start1 = 1'b0; vin.vsync = 1'b0;
        tick();
        check("stop_prio_busy", busy1, 0);
        pix("stop_nodraw", 0, 100, 768, 12'h400, 12'h400);
        drain();
        pulse_start1();
        pix("restart_top", 0, 100, 768, 12'h401, 12'hF0F);
        drain();
        tbg = 1'b1;
        pix("transp_bg", 0, 101, 768, 12'h402, 12'h402);
        pix("transp_fg", 0, 100, 768, 12'h403, 12'hF0F);
        drain();
        tbg = 1'b0;

        start2 = 1'b1; tick(); start2 = 1'b0; tick();
        pix("s2_col1",   1, 118, 768, 12'h500, 12'hF0F);
        pix("s2_col0",   1, 116, 768, 12'h501, 12'h00A);
        pix("s2_lastpx", 1, 355, 768, 12'h502, 12'h00A);
        pix("s2_width",  1, 356, 768, 12'h503, 12'h503);
        pix("s2_hsync",  1,  20,   5, 12'h504, 12'h504, 1'b0, 1'b1);
        drain();
        vin.hcount = 11'd118; vin.vcount = 11'd768;
        tick();
        check("s2_char_xy", xy2, 7'h01);
        check("s2_char_line", ln2, 0);
        vin.vcount = 11'd838;
        tick();
        check("s2_char_xy_row", xy2, 7'h21);
        check("s2_char_line_3", ln2, 3);

        vin.hcount = 11'd100; vin.vcount = 11'd768; vin.rgb = 12'h600;
        repeat (4) tick();
        check("pre_rst_rgb", vo1.rgb, 12'hF0F);
        check("pre_rst_busy", busy1, 1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_rgb", vo1.rgb, 0);
        check("mid_rst_hcount", vo1.hcount, 0);
        check("mid_rst_vcount", vo1.vcount, 0);
        check("mid_rst_busy", busy1, 0);
        check("mid_rst_char_xy", xy1, 0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_busy", busy1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/draw_text_scroller.md
Name: draw_text_scroller

Overview:
- Parametrised text-box overlay for the VGA pixel pipeline, the successor to the fixed 16x8-char credits drawer.
- Draws a 2^COL_W x 2^ROW_W character grid with integer pixel scaling, an optional transparent background and any font-ROM latency.
- Owns the credits scroll itself: a frame-synchronous FSM moves the box vertically from Y_START to Y_STOP, with optional looping.
- Sits between the background/ball stages and the VGA output, driving an external char-code ROM and font ROM.

Parameters:
- COL_W, 4, log2 of character columns.
- ROW_W, 3, log2 of character rows.
- SCALE_LOG2, 0, log2 of pixel magnification (0..2).
- ROM_LAT, 1, cycles from char_xy/char_line to valid char_pixels (1..3).
- Y_START, 768, initial box top (may be off-screen).
- Y_STOP, 100, final box top; Y_STOP < Y_START.
- STEP, 1, pixels moved per scroll step.
- FRAMES_PER_STEP, 2, frames between steps (>=1).

Ports:
- pclk  in  1  pixel clock
- rst  in  1  asynchronous reset, active-high
- hcount_in  in  11  horizontal counter
- vcount_in  in  11  vertical counter
- hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  timing
- rgb_in  in  12  upstream pixel
- xpos  in  12  box left edge
- char_pixels  in  8  font row from font ROM, bit7 = leftmost pixel
- color_fg, color_bg  in  12 each  glyph / background colours
- transparent_bg  in  1  1 = background pixels pass rgb_in
- start  in  1  pulse: begin scroll
- stop  in  1  pulse: abort to IDLE
- loop  in  1  1 = wrap to Y_START at Y_STOP
- hcount_out, vcount_out  out  11  delayed counters
- hsync_out, vsync_out, hblnk_out, vblnk_out  out  1 each  delayed timing
- rgb_out  out  12  pixel
- char_xy  out  ROW_W+COL_W  {row, col} to char-code ROM
- char_line  out  4  glyph row
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when box top reaches Y_STOP

Behaviour:
- Reset (async): all outputs 0, y_pos = Y_START, frame counter 0, state IDLE.
- Latency: every pixel-path output lags its input by exactly ROM_LAT+1 cycles.
- Timing and counters go through one delay line; a bench must see equal lag on all of them.
- Stage 1, registered: rect test, char_xy, char_line and pixel column index.
  - dx = (hcount_in - xpos) >> SCALE_LOG2; dy = (vcount_in - y_pos) >> SCALE_LOG2.
  - Compare in 13 bits: inside = hcount_in >= xpos, hcount_in < xpos + (8<<COL_W<<SCALE_LOG2), same form vertically with 16<<ROW_W.
  - char_xy = {dy[ROW_W+3:4], dx[COL_W+2:3]}; char_line = dy[3:0]; col = dx[2:0].
- Stages 2..ROM_LAT: carry inside/col/visible flags.
- Final stage, registered:
  - blanking -> rgb_out = 0;
  - else inside && drawing -> char_pixels[7-col] ? color_fg : (transparent_bg ? rgb_d : color_bg);
  - else rgb_d (rgb_in delayed to match).
- drawing = state in {SCROLL, HOLD}; outside the box, rgb passes unchanged.
- frame_tick: vsync_in rising edge (vsync_in registered one cycle). y_pos changes only on frame_tick, so a frame is never torn.
- FSM states:
  - IDLE: start -> SCROLL, y_pos = Y_START, frame counter = 0.
  - SCROLL: on frame_tick the frame counter increments; at FRAMES_PER_STEP-1 it clears and y_pos -= STEP, clamped to Y_STOP.
    - On reaching Y_STOP: done pulse.
    - loop=1 -> y_pos = Y_START on the next step tick, stay in SCROLL.
    - loop=0 -> HOLD.
  - HOLD: box stays at Y_STOP; start -> SCROLL from Y_START.
  - Any state: stop -> IDLE, y_pos = Y_START. stop has priority over start and over frame_tick.
- start while in SCROLL is ignored.
- Reset mid-scroll returns to IDLE immediately; the pixel pipeline clears.

Decomposition:
- Shared package gvideo_pkg: FSM state encoding, CHAR_W = 8, CHAR_H = 16, 11-bit counter and 12-bit RGB widths.
- Reuse the existing `delay` module for the timing/counter/rgb delay line (depth ROM_LAT+1).
- One natural sub-module, text_scroll_fsm: FSM, frame counter, y_pos, done.

Test Plan:
- Defaults, xpos=100, start, ROM model latency 1 returning 8'h80:
  - pixel (100,Y_START) after 2 cycles -> color_fg;
  - (101,Y_START) -> color_bg;
  - (99,Y_START) -> rgb_in;
  - (228,Y_START) -> rgb_in.
- SCALE_LOG2=1: hcount=xpos+18 -> char_xy col = 1, col index 1; box width 256 px.
- Scroll: FRAMES_PER_STEP=2, STEP=1 -> y_pos drops 1 per 2 vsync edges; after 1336 frames reach 100 -> done pulse exactly once, then HOLD, box stable.
- loop=1: at Y_STOP done pulses, y_pos = 768 on the next step tick, busy stays 1.
- stop asserted together with start and frame_tick -> IDLE, y_pos = 768, no pixels drawn; transparent_bg=1 -> background pixels equal rgb_in.
- Assert rst mid-scroll, off pclk edge -> all outputs 0 immediately, busy 0; ROM_LAT=3 -> hsync/rgb lag exactly 4 cycles.
